ps2_host_tx_ctrl: RTL



---
 rtl/ps2_host_tx_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx_ctrl.sv
// ps2_host_tx_ctrl: PS/2 host-to-device command sequencer (inhibit, RTS, start/8 data/odd parity/stop, device ACK).
// Latency: INHIBIT_CYC + 1 cycles of bus preamble, then paced by the device clock; done_o one cycle after completion.
// Backpressure: cmd_ready_o is low for the whole transaction; cmd_valid_i while busy is ignored.
module ps2_host_tx_ctrl #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       cmd_valid_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       done_o,
  output logic [1:0] err_code_o,
  output logic       rx_inhibit_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_RTS     = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_BUSWAIT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] INH_LAST    = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [1:0]       ERR_OK      = 2'd0;
  localparam logic [1:0]       ERR_NACK    = 2'd1;
  localparam logic [1:0]       ERR_TIMEOUT = 2'd2;
  // fall index that carries the stop bit; the frame is complete after it
  localparam logic [3:0]       STOP_FALL   = 4'd9;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       w_err_nxt;

  // c[2] is the oldest sample, c[0] the newest
  logic [2:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;

  // shared cycle counter: inhibit length, then transaction timeout
  logic [CNT_W-1:0] r_cnt;
  // number of device clock falls seen in SEND
  logic [3:0]       r_bit;
  // bit 0 is the value currently driven onto the data line; ones shift in so
  // the stop bit (released line) appears after parity
  logic [9:0]       r_frame;
  logic [1:0]       r_err_code;

  logic             w_fall;
  logic             w_dat_s;
  logic             w_bus_idle;
  logic             w_timeout;
  logic             w_accept;

  assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_dat_s    = r_dat_sync[1];
  assign w_bus_idle = r_clk_sync[1] & w_dat_s;
  assign w_timeout  = (r_cnt == TO_LAST);
  assign w_accept   = cmd_valid_i & (r_state == S_IDLE);

  // Synchronise the asynchronous bus lines; reset to the idle-high level so no false fall appears
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_i};
    end
  end

  // State register
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and completion code; timeout wins over a same-cycle fall
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_state_nxt = S_RTS;
        end
      end
      S_RTS: begin
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = ERR_TIMEOUT;
        end else if (w_fall && (r_bit == STOP_FALL)) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = ERR_TIMEOUT;
        end else if (w_fall) begin
          if (!w_dat_s) begin
            w_state_nxt = S_BUSWAIT;
          end else begin
            w_state_nxt = S_DONE;
            w_err_nxt   = ERR_NACK;
          end
        end
      end
      S_BUSWAIT: begin
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = ERR_TIMEOUT;
        end else if (w_bus_idle) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = ERR_OK;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch the frame, count cycles and falls, hold the completion code
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_frame    <= '1;
      r_err_code <= ERR_OK;
    end else begin
      r_err_code <= w_err_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // {odd parity, data LSB-first, start bit}
            r_frame <= {~^cmd_data_i, cmd_data_i, 1'b0};
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        S_INHIBIT: begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        S_RTS: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
        S_SEND: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (w_fall && !w_timeout) begin
            r_frame <= {1'b1, r_frame[9:1]};
            r_bit   <= r_bit + 4'd1;
          end
        end
        S_ACK, S_BUSWAIT: begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    cmd_ready_o  = 1'b0;
    done_o       = 1'b0;
    rx_inhibit_o = 1'b1;
    ps2_clk_oe_o = 1'b0;
    ps2_dat_oe_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o  = 1'b1;
        rx_inhibit_o = 1'b0;
      end
      S_INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
      end
      S_RTS: begin
        ps2_clk_oe_o = 1'b1;
        ps2_dat_oe_o = 1'b1;
      end
      S_SEND: begin
        ps2_dat_oe_o = ~r_frame[0];
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        done_o = 1'b0;
      end
    endcase
  end

  assign err_code_o = r_err_code;

endmodule
